// File: rtl/amt_recovery_seq.sv
// amt_recovery_seq
//   Sequences architectural-map-table recovery after an exception or branch
//   mispredict. A request stalls commit, drains one cycle so AMT writes from
//   the request cycle land, then walks the AMT four entries per cycle and
//   forwards each group to the rename map table through its four write ports.
//   Owns the AMT read-address mux: commit destinations in normal operation,
//   walk counter during recovery.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   recoverReq_i                 recovery request from the active list
//   commitDest{0..3}_i           logical destination of committing slot k
//   amtRdAddr{0..3}_o            AMT read address, port k
//   amtRdData{0..3}_i            AMT read data, port k (same-cycle read)
//   rmtWe_o                      RMT group write enable (all four ports)
//   rmtPacket{0..3}_o            {logical, physical} for RMT port k
//   commitStall_o                active list must not commit while high
//   flRestore_o                  one-cycle free-list restore pulse
//   recoverBusy_o                high while a recovery is in progress
//   recoverDone_o                one-cycle completion pulse
//   dbg_state                    current FSM state (IDLE=0 DRAIN=1 WALK=2 DONE=3)
//
// Handshake: recoverReq_i is sampled only in IDLE; while busy or in DONE it is
// ignored. A request still high in the first IDLE cycle starts a new recovery.
module amt_recovery_seq #(
  parameter int SIZE_RMT          = 32,
  parameter int SIZE_RMT_LOG      = 5,
  parameter int SIZE_PHYSICAL_LOG = 7
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    recoverReq_i,
  input  logic [SIZE_RMT_LOG-1:0]                 commitDest0_i,
  input  logic [SIZE_RMT_LOG-1:0]                 commitDest1_i,
  input  logic [SIZE_RMT_LOG-1:0]                 commitDest2_i,
  input  logic [SIZE_RMT_LOG-1:0]                 commitDest3_i,
  output logic [SIZE_RMT_LOG-1:0]                 amtRdAddr0_o,
  output logic [SIZE_RMT_LOG-1:0]                 amtRdAddr1_o,
  output logic [SIZE_RMT_LOG-1:0]                 amtRdAddr2_o,
  output logic [SIZE_RMT_LOG-1:0]                 amtRdAddr3_o,
  input  logic [SIZE_PHYSICAL_LOG-1:0]            amtRdData0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]            amtRdData1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]            amtRdData2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]            amtRdData3_i,
  output logic                                    rmtWe_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket0_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket1_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket2_o,
  output logic [SIZE_RMT_LOG+SIZE_PHYSICAL_LOG-1:0] rmtPacket3_o,
  output logic                                    commitStall_o,
  output logic                                    flRestore_o,
  output logic                                    recoverBusy_o,
  output logic                                    recoverDone_o,
  output logic [1:0]                              dbg_state
);

  localparam int PKT_W = SIZE_RMT_LOG + SIZE_PHYSICAL_LOG;
  localparam logic [SIZE_RMT_LOG-1:0] LAST_GROUP = SIZE_RMT_LOG'(SIZE_RMT - 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WALK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [SIZE_RMT_LOG-1:0] walk_cnt, walk_cnt_next;

  logic [SIZE_RMT_LOG-1:0]      dest     [4];
  logic [SIZE_RMT_LOG-1:0]      lane_idx [4];
  logic [SIZE_RMT_LOG-1:0]      rd_addr  [4];
  logic [SIZE_PHYSICAL_LOG-1:0] rd_data  [4];
  logic [PKT_W-1:0]             pkt      [4];

  logic in_walk;

  assign dest[0] = commitDest0_i;
  assign dest[1] = commitDest1_i;
  assign dest[2] = commitDest2_i;
  assign dest[3] = commitDest3_i;

  assign rd_data[0] = amtRdData0_i;
  assign rd_data[1] = amtRdData1_i;
  assign rd_data[2] = amtRdData2_i;
  assign rd_data[3] = amtRdData3_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      walk_cnt <= '0;
    end else begin
      state    <= state_next;
      walk_cnt <= walk_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    walk_cnt_next = walk_cnt;
    case (state)
      IDLE: begin
        if (recoverReq_i) state_next = DRAIN;
      end
      DRAIN: begin
        walk_cnt_next = '0;
        state_next    = WALK;
      end
      WALK: begin
        // Counter wraps to 0 after the last group; harmless since DRAIN reloads it.
        walk_cnt_next = walk_cnt + SIZE_RMT_LOG'(4);
        if (walk_cnt == LAST_GROUP) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_walk = (state == WALK);

  // Per-port lane: entry walk_cnt+k during the walk, truncated to the index width.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane_idx[k] = walk_cnt + SIZE_RMT_LOG'(k);
    assign rd_addr[k]  = in_walk ? lane_idx[k] : dest[k];
    assign pkt[k]      = in_walk ? {lane_idx[k], rd_data[k]} : '0;
  end

  assign amtRdAddr0_o = rd_addr[0];
  assign amtRdAddr1_o = rd_addr[1];
  assign amtRdAddr2_o = rd_addr[2];
  assign amtRdAddr3_o = rd_addr[3];

  assign rmtPacket0_o = pkt[0];
  assign rmtPacket1_o = pkt[1];
  assign rmtPacket2_o = pkt[2];
  assign rmtPacket3_o = pkt[3];

  assign rmtWe_o       = in_walk;
  assign commitStall_o = (state != IDLE);
  assign recoverBusy_o = (state != IDLE);
  assign flRestore_o   = (state == DONE);
  assign recoverDone_o = (state == DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_amt_recovery_seq.sv
module tb_amt_recovery_seq;

  localparam int N   = 32;
  localparam int LW  = 5;
  localparam int PW  = 7;
  localparam int W   = LW + PW;

  logic          clk;
  logic          reset;
  logic          recoverReq;
  logic [LW-1:0] dest  [4];
  logic [LW-1:0] addr  [4];
  logic [PW-1:0] rdata [4];
  logic [W-1:0]  pkt   [4];
  logic          rmt_we, stall, fl_restore, busy, done;
  logic [1:0]    dbg_state;

  logic [PW-1:0] amt [N];

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference: a recovery accepted in cycle S occupies cycles
  // S+1 (drain), S+2..S+9 (walk group p-2), S+10 (done).
  int cyc     = 0;
  int m_start = -1000;
  int p_now;
  always_comb p_now = cyc - m_start;

  always @(posedge clk) begin
    if (reset) m_start <= -1000;
    else if (!(p_now >= 1 && p_now <= 10) && recoverReq) m_start <= cyc;
    cyc <= cyc + 1;
  end

  logic [W-1:0] exp_q[$];
  int           seen [N];

  amt_recovery_seq dut (
    .clk           (clk),
    .reset         (reset),
    .recoverReq_i  (recoverReq),
    .commitDest0_i (dest[0]),
    .commitDest1_i (dest[1]),
    .commitDest2_i (dest[2]),
    .commitDest3_i (dest[3]),
    .amtRdAddr0_o  (addr[0]),
    .amtRdAddr1_o  (addr[1]),
    .amtRdAddr2_o  (addr[2]),
    .amtRdAddr3_o  (addr[3]),
    .amtRdData0_i  (rdata[0]),
    .amtRdData1_i  (rdata[1]),
    .amtRdData2_i  (rdata[2]),
    .amtRdData3_i  (rdata[3]),
    .rmtWe_o       (rmt_we),
    .rmtPacket0_o  (pkt[0]),
    .rmtPacket1_o  (pkt[1]),
    .rmtPacket2_o  (pkt[2]),
    .rmtPacket3_o  (pkt[3]),
    .commitStall_o (stall),
    .flRestore_o   (fl_restore),
    .recoverBusy_o (busy),
    .recoverDone_o (done),
    .dbg_state     (dbg_state)
  );

  // AMT model with combinational read
  assign rdata[0] = amt[addr[0]];
  assign rdata[1] = amt[addr[1]];
  assign rdata[2] = amt[addr[2]];
  assign rdata[3] = amt[addr[3]];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset      = 1'b1;
    recoverReq = 1'b0;
    for (int i = 0; i < 4; i++) dest[i] = '0;
    for (int i = 0; i < N; i++) amt[i] = '0;
  end

  // driver: apply inputs just after the edge, return at the following negedge
  task automatic tick(input logic req, input logic rst);
    @(posedge clk);
    #1;
    recoverReq = req;
    reset      = rst;
    @(negedge clk);
  endtask

  task automatic rand_dest();
    for (int k = 0; k < 4; k++) dest[k] = LW'($urandom_range(0, N-1));
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    dest[0] = 5'd3; dest[1] = 5'd7; dest[2] = 5'd9; dest[3] = 5'd30;
    tick(1'b0, 1'b0);
    n_checks++;
    if ({addr[0], addr[1], addr[2], addr[3]} !== {5'd3, 5'd7, 5'd9, 5'd30})
      $display("FAIL reset_addr got %0d,%0d,%0d,%0d exp 3,7,9,30", addr[0], addr[1], addr[2], addr[3]);
    else n_pass++;
    n_checks++;
    if ({rmt_we, stall, busy, done, fl_restore} !== 5'b0)
      $display("FAIL reset_outputs got we/stall/busy/done/fl=%b exp 00000",
               {rmt_we, stall, busy, done, fl_restore});
    else n_pass++;
    n_checks++;
    if (pkt[0] !== '0) $display("FAIL reset_pkt got %0h exp 0", pkt[0]);
    else n_pass++;
  endtask

  task automatic test_walk();
    int bad_pkt, bad_addr, bad_ctl;
    logic [LW-1:0] l;
    logic [W-1:0]  e;
    for (int i = 0; i < N; i++) amt[i] = PW'(i + 64);
    bad_pkt = 0; bad_addr = 0; bad_ctl = 0;
    tick(1'b1, 1'b0);                       // cycle T
    for (int j = 1; j <= 11; j++) begin
      rand_dest();
      tick(1'b0, 1'b0);                     // cycle T+j
      if (rmt_we !== (j >= 2 && j <= 9)) bad_ctl++;
      if (done !== (j == 10) || fl_restore !== (j == 10)) bad_ctl++;
      if (stall !== (j <= 10) || busy !== (j <= 10)) bad_ctl++;
      for (int k = 0; k < 4; k++) begin
        if (j >= 2 && j <= 9) begin
          l = LW'(4 * (j - 2) + k);
          e = {l, PW'(64 + 4 * (j - 2) + k)};
          if (pkt[k] !== e) begin
            bad_pkt++;
            $display("FAIL walk_pkt cyc T+%0d port %0d got %0h exp %0h", j, k, pkt[k], e);
          end
          if (addr[k] !== l) bad_addr++;
        end else begin
          if (pkt[k] !== '0) bad_pkt++;
          if (addr[k] !== dest[k]) bad_addr++;
        end
      end
      if (j == 1) begin
        n_checks++;
        if (dbg_state !== 2'd1) $display("FAIL walk_drain got state %0d exp 1", dbg_state);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad_pkt !== 0) $display("FAIL walk_packets got %0d bad exp 0", bad_pkt);
    else n_pass++;
    n_checks++;
    if (bad_addr !== 0) $display("FAIL walk_addr got %0d bad exp 0", bad_addr);
    else n_pass++;
    n_checks++;
    if (bad_ctl !== 0) $display("FAIL walk_timing got %0d bad exp 0", bad_ctl);
    else n_pass++;
  endtask

  task automatic test_ignore_req();
    int we_cnt, done_cnt, busy_cnt;
    we_cnt = 0; done_cnt = 0; busy_cnt = 0;
    tick(1'b1, 1'b0);
    for (int j = 1; j <= 15; j++) begin
      tick((j == 4) || (j == 10), 1'b0);    // pulses during WALK and during DONE
      if (rmt_we === 1'b1) we_cnt++;
      if (done === 1'b1)   done_cnt++;
      if (busy === 1'b1)   busy_cnt++;
    end
    n_checks++;
    if (we_cnt !== 8) $display("FAIL ignore_we_cycles got %0d exp 8", we_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL ignore_done_pulses got %0d exp 1", done_cnt);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 10) $display("FAIL ignore_busy_cycles got %0d exp 10", busy_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0);                       // T
    for (int j = 1; j <= 5; j++) tick(1'b0, j == 5);  // reset in 4th walk cycle
    rand_dest();
    tick(1'b0, 1'b0);
    n_checks++;
    if ({rmt_we, stall, busy, done, fl_restore} !== 5'b0 || pkt[1] !== '0)
      $display("FAIL midreset_outputs got ctl=%b pkt1=%0h exp 00000/0",
               {rmt_we, stall, busy, done, fl_restore}, pkt[1]);
    else n_pass++;
    n_checks++;
    if (addr[2] !== dest[2]) $display("FAIL midreset_addr got %0d exp %0d", addr[2], dest[2]);
    else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);                       // first walk cycle
    n_checks++;
    if (rmt_we !== 1'b1 || pkt[0] !== {5'd0, amt[0]} || pkt[3] !== {5'd3, amt[3]})
      $display("FAIL midreset_restart got we=%b pkt0=%0h pkt3=%0h exp 1/%0h/%0h",
               rmt_we, pkt[0], pkt[3], {5'd0, amt[0]}, {5'd3, amt[3]});
    else n_pass++;
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0);
  endtask

  task automatic test_held_req();
    int bad;
    bit eb, ed;
    bad = 0;
    for (int j = 0; j <= 24; j++) begin
      tick(j < 12, 1'b0);
      eb = (j >= 1 && j <= 10) || (j >= 12 && j <= 21);
      ed = (j == 10) || (j == 21);
      if (busy !== eb || done !== ed) begin
        bad++;
        $display("FAIL held_cycle T+%0d got busy=%b done=%b exp %b/%b", j, busy, done, eb, ed);
      end
      if (j == 12) begin
        n_checks++;
        if (dbg_state !== 2'd1) $display("FAIL held_second_drain got state %0d exp 1", dbg_state);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad !== 0) $display("FAIL held_sequence got %0d bad exp 0", bad);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    logic          req;
    logic [W-1:0]  e;
    int            idx, bad_cov, bad_ctl, n_rec;
    bad_ctl = 0; n_rec = 0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      req = (c < 370) && ($urandom_range(0, 7) == 0);
      if (!(p_now >= 1 && p_now <= 10) && !recoverReq) begin
        idx = $urandom_range(0, N-1);
        amt[idx] = PW'($urandom);
      end
      rand_dest();
      tick(req, 1'b0);
      if (p_now == 1) begin
        for (int i = 0; i < N; i++) begin
          exp_q.push_back({LW'(i), amt[i]});
          seen[i] = 0;
        end
      end
      if (rmt_we !== (p_now >= 2 && p_now <= 9) || done !== (p_now == 10) ||
          busy !== (p_now >= 1 && p_now <= 10)) begin
        bad_ctl++;
        $display("FAIL sb_control cyc %0d got we=%b done=%b busy=%b phase %0d", cyc, rmt_we, done, busy, p_now);
      end
      if (!(p_now >= 2 && p_now <= 9)) begin
        for (int k = 0; k < 4; k++) if (addr[k] !== dest[k]) bad_ctl++;
      end
      if (rmt_we === 1'b1) begin
        n_checks++;
        if (stall !== 1'b1) $display("FAIL sb_stall got %b exp 1", stall);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
          seen[pkt[k][W-1:PW]]++;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_extra_write got %0h exp none", pkt[k]);
          end else begin
            e = exp_q.pop_front();
            if (pkt[k] !== e) $display("FAIL sb_packet got %0h exp %0h", pkt[k], e);
            else n_pass++;
          end
        end
      end
      if (done === 1'b1) begin
        n_rec++;
        bad_cov = 0;
        for (int i = 0; i < N; i++) if (seen[i] != 1) bad_cov++;
        n_checks++;
        if (bad_cov !== 0) $display("FAIL sb_coverage got %0d entries not written once exp 0", bad_cov);
        else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (bad_ctl !== 0) $display("FAIL sb_timing got %0d bad exp 0", bad_ctl);
    else n_pass++;
    n_checks++;
    if (n_rec < 3) $display("FAIL sb_recoveries got %0d exp >=3", n_rec);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_ignore_req();
    test_reset_mid();
    test_held_req();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
